// File: rtl/surf_id_pkg.sv
// Shared constants and state encoding for the SURF identification reader.
package surf_id_pkg;

   localparam logic [31:0] ID_DEVICE_ADR  = 32'h0000_0000;
   localparam logic [31:0] ID_VERSION_ADR = 32'h0000_0004;
   localparam logic [31:0] ID_DNA_ADR     = 32'h0000_0008;
   localparam logic [31:0] DNA_LOAD_WORD  = 32'h8000_0000;
   localparam int          DNA_BITS_DEF   = 96;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      GAP,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/surf_id_reader.sv
// Wishbone initiator that fetches DEVICE, VERSION and the device DNA after
// reset or on request, and holds them as static registered outputs.
module surf_id_reader
   import surf_id_pkg::*;
#(
   parameter int WB_ADR_BITS = 11,
   parameter int DNA_BITS    = DNA_BITS_DEF,
   parameter int TIMEOUT     = 255,
   parameter int GAP_CYCLES  = 2,
   parameter int AUTO_START  = 1
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_n_i,
   input  logic                   start_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [31:0]            device_o,
   output logic [31:0]            version_o,
   output logic [DNA_BITS-1:0]    dna_o,
   output logic                   wb_cyc_o,
   output logic                   wb_stb_o,
   output logic                   wb_we_o,
   output logic [WB_ADR_BITS-1:0] wb_adr_o,
   output logic [31:0]            wb_dat_o,
   output logic [3:0]             wb_sel_o,
   input  logic                   wb_ack_i,
   input  logic                   wb_err_i,
   input  logic                   wb_rty_i,
   input  logic [31:0]            wb_dat_i
);

   localparam logic [6:0] LAST_STEP = 7'(DNA_BITS + 3);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

   state_t                   state_q, state_d;
   logic [6:0]               step_q, step_d;
   logic [7:0]               cnt_q, cnt_d;
   logic                     auto_q, req_q;
   logic                     cyc_q, cyc_d;
   logic                     we_q, we_d;
   logic [WB_ADR_BITS-1:0]   adr_q, adr_d;
   logic [31:0]              dat_q, dat_d;
   logic [3:0]               sel_q, sel_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic [31:0]              device_q, device_d;
   logic [31:0]              version_q, version_d;
   logic [DNA_BITS-1:0]      dna_q, dna_d;
   logic [6:0]               dna_idx;
   logic                     launch, fresh, abort;

   assign dna_idx = step_q - 7'd3;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      device_d  = device_q;
      version_d = version_q;
      dna_d     = dna_q;
      launch    = 1'b0;
      fresh     = 1'b0;
      abort     = 1'b0;

      case (state_q)
         IDLE: fresh = req_q;
         ISSUE: begin
            // err outranks rty outranks ack; data is only taken on a clean ack
            if (wb_err_i || wb_rty_i) begin
               abort = 1'b1;
            end else if (wb_ack_i) begin
               if (step_q == 7'd0) begin
                  device_d = wb_dat_i;
               end else if (step_q == 7'd1) begin
                  version_d = wb_dat_i;
               end else if (step_q >= 7'd3) begin
                  dna_d[dna_idx] = wb_dat_i[0];
               end
               step_d  = step_q + 7'd1;
               cnt_d   = 8'd0;
               cyc_d   = 1'b0;
               state_d = GAP;
            end else if (cnt_q == TO_LAST) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (step_q == LAST_STEP) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (cnt_q == GAP_LAST) begin
               launch = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE, ERROR: fresh = req_q;
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d = ERROR;
         cyc_d   = 1'b0;
         busy_d  = 1'b0;
         err_d   = 1'b1;
         cnt_d   = 8'd0;
      end

      if (fresh) begin
         step_d = 7'd0;
         done_d = 1'b0;
         err_d  = 1'b0;
         launch = 1'b1;
      end

      // bus fields are registered at launch and held for the whole transaction
      if (launch) begin
         state_d = ISSUE;
         cnt_d   = 8'd0;
         cyc_d   = 1'b1;
         busy_d  = 1'b1;
         we_d    = 1'b0;
         sel_d   = 4'b1111;
         dat_d   = 32'd0;
         if (step_d == 7'd0) begin
            adr_d = ID_DEVICE_ADR[WB_ADR_BITS-1:0];
         end else if (step_d == 7'd1) begin
            adr_d = ID_VERSION_ADR[WB_ADR_BITS-1:0];
         end else if (step_d == 7'd2) begin
            adr_d = ID_DNA_ADR[WB_ADR_BITS-1:0];
            we_d  = 1'b1;
            sel_d = 4'b1000;
            dat_d = DNA_LOAD_WORD;
         end else begin
            adr_d = ID_DNA_ADR[WB_ADR_BITS-1:0];
         end
      end
   end

   // start requests (and the post-reset auto request) pass through req_q so
   // the bus comes up one edge after the request is sampled
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= IDLE;
         step_q    <= 7'd0;
         cnt_q     <= 8'd0;
         auto_q    <= (AUTO_START != 0);
         req_q     <= 1'b0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= 32'd0;
         sel_q     <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         device_q  <= 32'd0;
         version_q <= 32'd0;
         dna_q     <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         cnt_q     <= cnt_d;
         auto_q    <= 1'b0;
         req_q     <= start_i | auto_q;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         device_q  <= device_d;
         version_q <= version_d;
         dna_q     <= dna_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign device_o  = device_q;
   assign version_o = version_q;
   assign dna_o     = dna_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = we_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_sel_o  = sel_q;

endmodule

// File: tb/tb_surf_id_reader.sv
// Bench for surf_id_reader: model ID target, bus monitor and result scoreboard.
module tb_surf_id_reader;

   localparam logic [95:0] DNA_PAT  = 96'h0123_4567_89AB_CDEF_F00D_CAFE;
   localparam logic [31:0] DEV_SURF = 32'h5355_5246;
   localparam logic [31:0] VER0     = 32'h0001_0203;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy, done, err_o;
   logic [31:0] device, version;
   logic [95:0] dna;
   logic        cyc, stb, we;
   logic [10:0] adr;
   logic [31:0] wdat;
   logic [3:0]  sel;
   logic        ack, err, rty;
   logic [31:0] rdat;

   surf_id_reader dut (
      .wb_clk_i  (clk),
      .wb_rst_n_i(rst_n),
      .start_i   (start),
      .busy_o    (busy),
      .done_o    (done),
      .err_o     (err_o),
      .device_o  (device),
      .version_o (version),
      .dna_o     (dna),
      .wb_cyc_o  (cyc),
      .wb_stb_o  (stb),
      .wb_we_o   (we),
      .wb_adr_o  (adr),
      .wb_dat_o  (wdat),
      .wb_sel_o  (sel),
      .wb_ack_i  (ack),
      .wb_err_i  (err),
      .wb_rty_i  (rty),
      .wb_dat_i  (rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n++;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
      end
   endtask

   // model target: registered response after lat cycles of stb, DNA shifted out LSB first
   int          lat     = 1;
   int          hold_tx = -1;
   int          err_tx  = -1;
   int          rty_tx  = -1;
   logic [31:0] tgt_dev = DEV_SURF;
   logic [31:0] tgt_ver = VER0;
   int          tx;
   int          lcnt;
   int          cur_step;
   logic [95:0] sr;

   assign cur_step = (adr == 11'h000) ? 0 : tx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack <= 1'b0; err <= 1'b0; rty <= 1'b0;
         lcnt <= 0; tx <= 0; sr <= '0; rdat <= '0;
      end else if (ack || err || rty) begin
         ack <= 1'b0; err <= 1'b0; rty <= 1'b0;
         if (ack && !we && adr == 11'h008) sr <= sr >> 1;
      end else if (stb) begin
         if (cur_step != hold_tx) begin
            if (lcnt == lat - 1) begin
               lcnt <= 0;
               tx   <= cur_step + 1;
               if (cur_step == rty_tx) begin
                  rty <= 1'b1;
               end else begin
                  ack <= 1'b1;
                  err <= (cur_step == err_tx);
               end
               if (adr == 11'h000)      rdat <= tgt_dev;
               else if (adr == 11'h004) rdat <= tgt_ver;
               else                     rdat <= {31'd0, sr[0]};
               if (we && wdat == 32'h8000_0000) sr <= DNA_PAT;
            end else begin
               lcnt <= lcnt + 1;
            end
         end
      end else begin
         lcnt <= 0;
      end
   end

   // bus monitor
   int gap_run   = 0;
   bit gap_busy  = 1'b0;
   bit prev_term = 1'b0;
   int wr_cnt    = 0;
   int dev_reads = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         gap_run = 0; gap_busy = 1'b0; prev_term = 1'b0;
      end else begin
         if (prev_term) check("stb_after_term", {95'd0, stb}, 96'd0);
         prev_term = stb & (ack | err | rty);
         if (!stb) begin
            if (gap_run == 0) gap_busy = 1'b1;
            gap_run++;
            gap_busy = gap_busy & busy;
         end else begin
            if (gap_run > 0 && gap_busy) check("gap_len", 96'(gap_run), 96'd2);
            gap_run = 0;
         end
         if (stb && ack && !err && we) begin
            wr_cnt++;
            check("wr_adr", {85'd0, adr}, 96'h008);
            check("wr_sel", {92'd0, sel}, 96'h8);
            check("wr_dat", {64'd0, wdat}, 96'h8000_0000);
         end
         if (stb && ack && !we && adr == 11'h000) dev_reads++;
      end
   end

   typedef struct {
      logic        done;
      logic        err;
      logic [31:0] dev;
      logic [31:0] ver;
      logic [95:0] dna;
      int          cycles;
   } exp_t;

   exp_t sbq[$];
   int   t0;

   task automatic push_exp(input logic d, input logic e, input logic [31:0] dv,
                           input logic [31:0] vr, input int cycles);
      exp_t x;
      x.done = d; x.err = e; x.dev = dv; x.ver = vr; x.dna = DNA_PAT; x.cycles = cycles;
      sbq.push_back(x);
   endtask

   task automatic start_seq();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 t0 = cyc_n;
      start = 1'b0;
      @(posedge clk);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 t0 = cyc_n;
      @(posedge clk);
   endtask

   task automatic wait_result(input string tag);
      exp_t e;
      bit   hit = 1'b0;
      int   n   = 0;
      e = sbq.pop_front();
      while (!hit && n < 2000) begin
         @(negedge clk);
         n++;
         hit = done | err_o;
      end
      check({tag, "_seen"}, {95'd0, hit}, 96'd1);
      check({tag, "_done"}, {95'd0, done}, {95'd0, e.done});
      check({tag, "_err"}, {95'd0, err_o}, {95'd0, e.err});
      check({tag, "_dev"}, {64'd0, device}, {64'd0, e.dev});
      check({tag, "_ver"}, {64'd0, version}, {64'd0, e.ver});
      check({tag, "_dna"}, dna, e.dna);
      check({tag, "_busy"}, {95'd0, busy}, 96'd0);
      check({tag, "_cyc"}, {95'd0, cyc}, 96'd0);
      if (hit) check({tag, "_cycles"}, 96'(cyc_n - t0), 96'(e.cycles));
   endtask

   int wr0;
   int d0;
   int n;

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {95'd0, busy}, 96'd0);
      check("rst_done", {95'd0, done}, 96'd0);
      check("rst_err", {95'd0, err_o}, 96'd0);
      check("rst_stb", {94'd0, cyc, stb}, 96'd0);
      check("rst_adr", {85'd0, adr}, 96'd0);
      check("rst_bus", {59'd0, we, sel, wdat}, 96'd0);
      check("rst_ids", {32'd0, device, version}, 96'd0);
      check("rst_dna", dna, 96'd0);

      // auto start after reset release
      wr0 = wr_cnt;
      push_exp(1'b1, 1'b0, DEV_SURF, VER0, 396);
      release_rst();
      wait_result("auto");
      check("auto_writes", 96'(wr_cnt - wr0), 96'd1);

      // ack withheld on step 5 -> timeout abort, then clean rerun
      tgt_dev = 32'h1111_2222;
      hold_tx = 5;
      push_exp(1'b0, 1'b1, 32'h1111_2222, VER0, 276);
      start_seq();
      wait_result("tmo");
      hold_tx = -1;
      tgt_dev = DEV_SURF;
      push_exp(1'b1, 1'b0, DEV_SURF, VER0, 396);
      start_seq();
      wait_result("rerun");

      // err together with ack on step 1 -> version not overwritten
      tgt_ver = 32'hDEAD_BEEF;
      err_tx  = 1;
      push_exp(1'b0, 1'b1, DEV_SURF, VER0, 7);
      start_seq();
      wait_result("errack");
      err_tx = -1;

      // rty on step 3 aborts, earlier reads already captured
      tgt_ver = 32'h0002_0000;
      rty_tx  = 3;
      push_exp(1'b0, 1'b1, DEV_SURF, 32'h0002_0000, 15);
      start_seq();
      wait_result("rty");
      rty_tx  = -1;
      tgt_ver = VER0;

      // start during busy is ignored; reset at step 40 clears everything
      start_seq();
      n = 0;
      while (tx < 10 && n < 500) begin @(negedge clk); n++; end
      d0 = dev_reads;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (tx < 40 && n < 500) begin @(negedge clk); n++; end
      check("reach_step40", {95'd0, tx >= 40}, 96'd1);
      check("start_ignored", 96'(dev_reads), 96'(d0));
      check("busy_at_40", {95'd0, busy}, 96'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_stb", {94'd0, cyc, stb}, 96'd0);
      check("arst_flags", {93'd0, busy, done, err_o}, 96'd0);
      check("arst_ids", {32'd0, device, version}, 96'd0);
      check("arst_dna", dna, 96'd0);
      repeat (2) @(posedge clk);
      push_exp(1'b1, 1'b0, DEV_SURF, VER0, 396);
      release_rst();
      wait_result("restart");

      // three-cycle ack latency
      lat = 3;
      push_exp(1'b1, 1'b0, DEV_SURF, VER0, 594);
      start_seq();
      wait_result("lat3");
      lat = 1;

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
